// File: rtl/gorev_planlayici_if.sv
// Handshake bundle between the filter task scheduler and its surroundings.
// The slave modport is the scheduler's view. The master modport is the view of
// the environment that issues tasks and hosts the filter datapath.
interface gorev_planlayici_if #(
   parameter int COEF_BIT = 8,
   parameter int ROW_W    = 4,
   parameter int COL_W    = 4
) ();
   logic                gorev_gecerli_i;
   logic [1:0]          gorev_kod_i;
   logic                gorev_hazir_o;
   logic                gorev_iptal_i;
   logic                cfg_gecerli_o;
   logic [3:0]          cfg_idx_o;
   logic [COEF_BIT-1:0] cfg_veri_o;
   logic                cfg_hazir_i;
   logic                blok_gecerli_o;
   logic [ROW_W-1:0]    blok_row_o;
   logic [COL_W-1:0]    blok_col_o;
   logic                blok_hazir_i;
   logic                res_gecerli_i;
   logic                res_hazir_i;
   logic                gorev_aktif_o;
   logic                res_bitti_o;
   logic                hata_o;

   modport slave (
      input  gorev_gecerli_i, gorev_kod_i, gorev_iptal_i, cfg_hazir_i,
             blok_hazir_i, res_gecerli_i, res_hazir_i,
      output gorev_hazir_o, cfg_gecerli_o, cfg_idx_o, cfg_veri_o,
             blok_gecerli_o, blok_row_o, blok_col_o, gorev_aktif_o,
             res_bitti_o, hata_o
   );

   modport master (
      output gorev_gecerli_i, gorev_kod_i, gorev_iptal_i, cfg_hazir_i,
             blok_hazir_i, res_gecerli_i, res_hazir_i,
      input  gorev_hazir_o, cfg_gecerli_o, cfg_idx_o, cfg_veri_o,
             blok_gecerli_o, blok_row_o, blok_col_o, gorev_aktif_o,
             res_bitti_o, hata_o
   );
endinterface

// File: rtl/gorev_planlayici.sv
// gorev_planlayici: task scheduler for the post-IDCT filter unit.
// It accepts one filter task per image and streams the 3x3 kernel plus the
// output shift into the datapath. It then requests image blocks in raster
// order, counts result pixels per block, and pulses res_bitti_o at frame end.
// Optional block watchdog: define GOREV_ZAMANASIMI_EN.
module gorev_planlayici #(
   parameter int PIXEL_BIT      = 8,
   parameter int COEF_BIT       = 8,
   parameter int BLOCK_SIZE     = 8,
   parameter int IMG_ROW_BLOCKS = 16,
   parameter int IMG_COL_BLOCKS = 16,
   parameter int ZAMANASIMI_LIM = 4096
) (
   input logic               clk_i,
   input logic               rst_i,
   gorev_planlayici_if.slave bus
);

   localparam int AREA  = BLOCK_SIZE * BLOCK_SIZE;
   localparam int PIX_W = $clog2(AREA) + 1;
   localparam int ROW_W = (IMG_ROW_BLOCKS > 1) ? $clog2(IMG_ROW_BLOCKS) : 1;
   localparam int COL_W = (IMG_COL_BLOCKS > 1) ? $clog2(IMG_COL_BLOCKS) : 1;

   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(AREA - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROW_BLOCKS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COL_BLOCKS - 1);
   localparam logic [3:0]       IDX_SHIFT = 4'd9;

   // Reject parameter sets the datapath cannot represent. The gaussian shift
   // of 4 needs a signed 4-bit coefficient, and the watchdog needs at least
   // two counts.
   if (PIXEL_BIT < 1 || COEF_BIT < 4 || BLOCK_SIZE < 1 || IMG_ROW_BLOCKS < 1 ||
       IMG_COL_BLOCKS < 1 || ZAMANASIMI_LIM < 2) begin : g_param_hata
      $error("gorev_planlayici: invalid parameter set");
   end

   typedef enum logic [2:0] {
      BOSTA,
      YAPILANDIR,
      BLOK_ISTE,
      BLOK_BEKLE,
      BITTI
   } durum_t;

   durum_t              r_state, w_state_next;
   logic [1:0]          r_kod, w_kod_next;
   logic [3:0]          r_idx, w_idx_next;
   logic [ROW_W-1:0]    r_row, w_row_next;
   logic [COL_W-1:0]    r_col, w_col_next;
   logic [PIX_W-1:0]    r_pix, w_pix_next;
   logic                r_hata, w_hata_next;

   logic                r_gorev_hazir;
   logic                r_cfg_gecerli;
   logic [COEF_BIT-1:0] r_cfg_veri;
   logic                r_blok_gecerli;
   logic                r_aktif;
   logic                r_bitti;

   logic                w_gorev_hs;
   logic                w_cfg_hs;
   logic                w_blok_hs;
   logic                w_res_hs;
   logic                w_son_blok;

`ifdef GOREV_ZAMANASIMI_EN
   localparam int WD_W = $clog2(ZAMANASIMI_LIM);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(ZAMANASIMI_LIM - 1);
   logic [WD_W-1:0]     r_wd, w_wd_next;
`endif

   // Returns the kernel coefficient (index 0..8, row-major) or the shift
   // amount (index 9) for each task code.
   function automatic logic [COEF_BIT-1:0] f_coef(input logic [1:0] kod, input logic [3:0] idx);
      int v;
      v = 0;
      case (kod)
         2'd0: case (idx)
                  4'd0, 4'd6: v = -1;
                  4'd2, 4'd8: v = 1;
                  4'd3:       v = -2;
                  4'd5:       v = 2;
                  default:    v = 0;
               endcase
         2'd1: case (idx)
                  4'd0, 4'd2: v = -1;
                  4'd1:       v = -2;
                  4'd6, 4'd8: v = 1;
                  4'd7:       v = 2;
                  default:    v = 0;
               endcase
         2'd2: case (idx)
                  4'd0, 4'd2, 4'd6, 4'd8: v = 1;
                  4'd1, 4'd3, 4'd5, 4'd7: v = 2;
                  4'd4, 4'd9:             v = 4;
                  default:                v = 0;
               endcase
         default: v = (idx == 4'd4) ? 1 : 0;
      endcase
      return COEF_BIT'(v);
   endfunction

   assign w_gorev_hs = r_gorev_hazir && bus.gorev_gecerli_i;
   assign w_cfg_hs   = r_cfg_gecerli && bus.cfg_hazir_i;
   assign w_blok_hs  = r_blok_gecerli && bus.blok_hazir_i;
   assign w_res_hs   = bus.res_gecerli_i && bus.res_hazir_i;
   assign w_son_blok = (r_row == ROW_LAST) && (r_col == COL_LAST);

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= BOSTA;
      else       r_state <= w_state_next;
   end

   // Next-state logic and counter updates. Abort overrides any transfer seen
   // in the same cycle. Stray result handshakes are flagged last, so a stray
   // pixel on the accept cycle still leaves the error flag set.
   always_comb begin
      w_state_next = r_state;
      w_kod_next   = r_kod;
      w_idx_next   = r_idx;
      w_row_next   = r_row;
      w_col_next   = r_col;
      w_pix_next   = r_pix;
      w_hata_next  = r_hata;
`ifdef GOREV_ZAMANASIMI_EN
      w_wd_next    = '0;
`endif

      case (r_state)
         BOSTA: begin
            if (w_gorev_hs) begin
               w_state_next = YAPILANDIR;
               w_kod_next   = bus.gorev_kod_i;
               w_idx_next   = 4'd0;
               w_hata_next  = 1'b0;
            end
         end
         YAPILANDIR: begin
            if (w_cfg_hs) begin
               if (r_idx == IDX_SHIFT) begin
                  w_state_next = BLOK_ISTE;
                  w_idx_next   = 4'd0;
                  w_row_next   = '0;
                  w_col_next   = '0;
               end else begin
                  w_idx_next = r_idx + 4'd1;
               end
            end
         end
         BLOK_ISTE: begin
            if (w_blok_hs) begin
               w_state_next = BLOK_BEKLE;
               w_pix_next   = '0;
            end
         end
         BLOK_BEKLE: begin
            if (w_res_hs) begin
               if (r_pix == PIX_LAST) begin
                  w_pix_next = '0;
                  if (w_son_blok) begin
                     w_state_next = BITTI;
                  end else begin
                     w_state_next = BLOK_ISTE;
                     if (r_col == COL_LAST) begin
                        w_col_next = '0;
                        w_row_next = r_row + 1'b1;
                     end else begin
                        w_col_next = r_col + 1'b1;
                     end
                  end
               end else begin
                  w_pix_next = r_pix + 1'b1;
               end
            end
         end
         BITTI: begin
            w_state_next = BOSTA;
            w_row_next   = '0;
            w_col_next   = '0;
         end
         default: w_state_next = BOSTA;
      endcase

      if (bus.gorev_iptal_i && r_state != BOSTA) begin
         w_state_next = BOSTA;
         w_idx_next   = 4'd0;
         w_row_next   = '0;
         w_col_next   = '0;
         w_pix_next   = '0;
      end

`ifdef GOREV_ZAMANASIMI_EN
      if ((r_state == BLOK_ISTE || r_state == BLOK_BEKLE) && w_state_next == r_state &&
          !w_blok_hs && !w_res_hs) begin
         if (r_wd == WD_LAST) begin
            w_state_next = BOSTA;
            w_row_next   = '0;
            w_col_next   = '0;
            w_pix_next   = '0;
            w_hata_next  = 1'b1;
         end else begin
            w_wd_next = r_wd + 1'b1;
         end
      end
`endif

      if (w_res_hs && r_state != BLOK_BEKLE) w_hata_next = 1'b1;
   end

   // Datapath counters and registered outputs. All outputs are decoded from
   // the next state so they appear together with the state they describe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_kod          <= 2'd0;
         r_idx          <= 4'd0;
         r_row          <= '0;
         r_col          <= '0;
         r_pix          <= '0;
         r_hata         <= 1'b0;
         r_gorev_hazir  <= 1'b1;
         r_cfg_gecerli  <= 1'b0;
         r_cfg_veri     <= '0;
         r_blok_gecerli <= 1'b0;
         r_aktif        <= 1'b0;
         r_bitti        <= 1'b0;
      end else begin
         r_kod          <= w_kod_next;
         r_idx          <= w_idx_next;
         r_row          <= w_row_next;
         r_col          <= w_col_next;
         r_pix          <= w_pix_next;
         r_hata         <= w_hata_next;
         r_gorev_hazir  <= (w_state_next == BOSTA);
         r_cfg_gecerli  <= (w_state_next == YAPILANDIR);
         r_cfg_veri     <= (w_state_next == YAPILANDIR) ? f_coef(w_kod_next, w_idx_next) : '0;
         r_blok_gecerli <= (w_state_next == BLOK_ISTE);
         r_aktif        <= (w_state_next != BOSTA);
         r_bitti        <= (w_state_next == BITTI);
      end
   end

`ifdef GOREV_ZAMANASIMI_EN
   // Idle-cycle counter for the watchdog; cleared on state entry and on
   // every block or result transfer.
   always_ff @(posedge clk_i) begin
      if (rst_i) r_wd <= '0;
      else       r_wd <= w_wd_next;
   end
`endif

   assign bus.gorev_hazir_o  = r_gorev_hazir;
   assign bus.cfg_gecerli_o  = r_cfg_gecerli;
   assign bus.cfg_idx_o      = r_idx;
   assign bus.cfg_veri_o     = r_cfg_veri;
   assign bus.blok_gecerli_o = r_blok_gecerli;
   assign bus.blok_row_o     = r_row;
   assign bus.blok_col_o     = r_col;
   assign bus.gorev_aktif_o  = r_aktif;
   assign bus.res_bitti_o    = r_bitti;
   assign bus.hata_o         = r_hata;

endmodule

// File: tb/tb_gorev_planlayici.sv
// Self-checking bench for gorev_planlayici with the default 16x16 block frame
// and an 8x8 block. Config words and block indices go through scoreboard
// queues that a negedge monitor drains.
module tb_gorev_planlayici;

   localparam int ROWS = 16;
   localparam int COLS = 16;
   localparam int AREA = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   gorev_planlayici_if #(.COEF_BIT(8), .ROW_W(4), .COL_W(4)) bus ();

   gorev_planlayici #(
      .PIXEL_BIT(8), .COEF_BIT(8), .BLOCK_SIZE(8),
      .IMG_ROW_BLOCKS(ROWS), .IMG_COL_BLOCKS(COLS), .ZAMANASIMI_LIM(16)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int testCount  = 0;
   int failCount  = 0;
   int bittiCount = 0;
   int cfgQ[$];
   int blkQ[$];
   logic       prevStall = 1'b0;
   logic [3:0] prevIdx   = 4'd0;

   int kTab [0:3][0:9] = '{
      '{-1,  0,  1, -2, 0, 2, -1, 0, 1, 0},
      '{-1, -2, -1,  0, 0, 0,  1, 2, 1, 0},
      '{ 1,  2,  1,  2, 4, 2,  1, 2, 1, 4},
      '{ 0,  0,  0,  0, 1, 0,  0, 0, 0, 0}
   };

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic tv, input logic [1:0] kod, input logic iptal,
                                input logic resV, input logic resR);
      bus.gorev_gecerli_i = tv;
      bus.gorev_kod_i     = kod;
      bus.gorev_iptal_i   = iptal;
      bus.res_gecerli_i   = resV;
      bus.res_hazir_i     = resR;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pushCfg(input int kod);
      for (int i = 0; i < 10; i++) cfgQ.push_back((i << 8) | (kTab[kod][i] & 8'hFF));
   endtask

   task automatic sendTask(input logic [1:0] kod);
      applyStimulus(1'b1, kod, 1'b0, 1'b0, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic feedPixels(input int n);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
      repeat (n) stepCycle();
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Waits (bounded) for a block request, lets it transfer, and reports how
   // many idle negedges passed before the request showed up.
   task automatic waitBlock(output int waited);
      bit ok;
      ok = 1'b0;
      waited = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.blok_gecerli_o && bus.blok_hazir_i) ok = 1'b1;
         else waited++;
      end
      checkOutput("blk_wait", 32'(ok), 32'd1);
      stepCycle();
   endtask

   // Scoreboard monitor: drains expected config words and block indices on
   // each transfer, checks that a stalled config word is held, counts
   // frame-done pulses.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.cfg_gecerli_o && bus.cfg_hazir_i) begin
            checkOutput("cfg_q_nonempty", 32'(cfgQ.size() > 0), 32'd1);
            if (cfgQ.size() > 0) checkOutput("cfg_word", {bus.cfg_idx_o, bus.cfg_veri_o}, cfgQ.pop_front());
         end
         if (prevStall) checkOutput("cfg_hold", {bus.cfg_gecerli_o, bus.cfg_idx_o}, {1'b1, prevIdx});
         prevStall = bus.cfg_gecerli_o && !bus.cfg_hazir_i;
         prevIdx   = bus.cfg_idx_o;
         if (bus.blok_gecerli_o && bus.blok_hazir_i) begin
            checkOutput("blk_q_nonempty", 32'(blkQ.size() > 0), 32'd1);
            if (blkQ.size() > 0) checkOutput("blk_idx", {bus.blok_row_o, bus.blok_col_o}, blkQ.pop_front());
         end
         if (bus.res_bitti_o) bittiCount++;
      end
   end

   // Main stimulus sequence.
   initial begin
      int w;
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      bus.cfg_hazir_i  = 1'b1;
      bus.blok_hazir_i = 1'b1;

      // Reset values.
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_hazir", 32'(bus.gorev_hazir_o), 32'd1);
      checkOutput("rst_outs", {bus.gorev_aktif_o, bus.cfg_gecerli_o, bus.blok_gecerli_o,
                               bus.res_bitti_o, bus.hata_o, bus.cfg_idx_o, bus.cfg_veri_o,
                               bus.blok_row_o, bus.blok_col_o}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Gaussian config timing, then the full frame for the same task.
      pushCfg(2);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) blkQ.push_back(r * 16 + c);
      sendTask(2'd2);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         checkOutput("cfg_cycle", {bus.cfg_gecerli_o, bus.cfg_idx_o}, {1'b1, 4'(c - 1)});
      end
      @(negedge clk);
      checkOutput("blk_first", {bus.blok_gecerli_o, bus.blok_row_o, bus.blok_col_o}, {1'b1, 8'd0});
      stepCycle();
      for (int b = 0; b < ROWS * COLS; b++) begin
         if (b > 0) begin
            waitBlock(w);
            if (b == 16) checkOutput("wrap_bubble", 32'(w), 32'd0);
         end
         feedPixels(AREA);
      end
      @(negedge clk);
      checkOutput("frame_bitti", {bus.res_bitti_o, bus.gorev_hazir_o}, {1'b1, 1'b0});
      @(negedge clk);
      checkOutput("frame_idle", {bus.res_bitti_o, bus.gorev_hazir_o}, {1'b0, 1'b1});
      checkOutput("frame_pulses", 32'(bittiCount), 32'd1);
      checkOutput("frame_blkq", 32'(blkQ.size()), 32'd0);
      stepCycle();

      // Sobel-x config under alternating backpressure.
      pushCfg(0);
      blkQ.push_back(0);
      bus.cfg_hazir_i = 1'b0;
      sendTask(2'd0);
      begin
         bit ok;
         ok = 1'b0;
         for (int i = 0; i < 60 && !ok; i++) begin
            bus.cfg_hazir_i = ~bus.cfg_hazir_i;
            @(negedge clk);
            ok = bus.blok_gecerli_o;
            stepCycle();
         end
         checkOutput("bp_done", 32'(ok), 32'd1);
      end
      bus.cfg_hazir_i = 1'b1;
      checkOutput("bp_cfgq", 32'(cfgQ.size()), 32'd0);

      // 63 pixels then a stall: no new request while the block is short.
      feedPixels(AREA - 1);
      repeat (8) begin
         @(negedge clk);
         checkOutput("stall_noreq", {bus.gorev_aktif_o, bus.blok_gecerli_o}, {1'b1, 1'b0});
      end
      stepCycle();
      feedPixels(1);

      // Run to block (3,7), then abort with a same-cycle result handshake.
      for (int b = 1; b <= 55; b++) begin
         blkQ.push_back((b / 16) * 16 + (b % 16));
         waitBlock(w);
         if (b < 55) feedPixels(AREA);
      end
      feedPixels(10);
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("abort_state", {bus.gorev_hazir_o, bus.gorev_aktif_o, bus.blok_gecerli_o, bus.hata_o},
                  32'b1000);
      repeat (3) @(negedge clk);
      checkOutput("abort_nobitti", 32'(bittiCount), 32'd1);
      stepCycle();

      // Stray pixel in BOSTA sets the sticky error until the next accept.
      feedPixels(1);
      @(negedge clk);
      checkOutput("stray_set", 32'(bus.hata_o), 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("stray_sticky", 32'(bus.hata_o), 32'd1);
      stepCycle();
      pushCfg(3);
      blkQ.push_back(0);
      sendTask(2'd3);
      @(negedge clk);
      checkOutput("stray_clear", {bus.hata_o, bus.gorev_aktif_o}, {1'b0, 1'b1});
      stepCycle();
      waitBlock(w);

      // No results while waiting on a block.
      repeat (20) stepCycle();
      @(negedge clk);
`ifdef GOREV_ZAMANASIMI_EN
      checkOutput("wd_timeout", {bus.gorev_aktif_o, bus.hata_o, bus.gorev_hazir_o}, {1'b0, 1'b1, 1'b1});
`else
      checkOutput("wd_absent", {bus.gorev_aktif_o, bus.hata_o, bus.blok_gecerli_o}, {1'b1, 1'b0, 1'b0});
      stepCycle();
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
`endif
      checkOutput("end_pulses", 32'(bittiCount), 32'd1);
      checkOutput("end_queues", 32'(cfgQ.size() + blkQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
